// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED blink sequencer.
//   led_state_e : sequencer phase (IDLE / ON / OFF / GAP)
//   timer_w()   : width of the phase down-counter for a given set of
//                 phase lengths; the counter only ever holds LEN-1.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_e;

  function automatic int timer_w(input int on_cyc, input int off_cyc, input int gap_cyc);
    int m;
    m = on_cyc;
    if (off_cyc > m) m = off_cyc;
    if (gap_cyc > m) m = gap_cyc;
    // Loaded values are at most m-1, so $clog2(m) bits suffice; keep >= 1 bit.
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by all blink phases.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : load load_val_i this edge (wins over counting)
//   load_val_i   : value to load (phase length minus one)
//   zero_o       : counter currently reads zero (last cycle of a phase)
// The counter stops at zero rather than wrapping.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_blink_seq.sv
// Sequenced LED driver: turns a one-cycle trigger into N timed blinks.
//   clk, rst_n : clock, async active-low reset
//   trig       : one-cycle start pulse; blink_cnt sampled with it
//   blink_cnt  : number of blinks (0 = ignore trigger)
//   rpt        : repeat the sequence after a GAP (sampled at sequence end)
//   stop       : abort at next edge, discards any pending retrigger
//   led        : registered LED drive, active-high
//   busy       : sequence in progress (decoded from registered state)
//   done       : registered one-cycle pulse on normal non-repeating end
//   dbg_state  : current sequencer state, for observation only
//
// Handshake: trig is a fire-and-forget pulse with no ready; while busy a
// nonzero trig is parked as a pending count (last write wins) and takes
// effect at the next GAP->ON, or as a restart right after a normal end.
module led_blink_seq
  import led_seq_pkg::*;
#(
  parameter int ON_CYC  = 12_500_000,
  parameter int OFF_CYC = 12_500_000,
  parameter int GAP_CYC = 50_000_000,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic [CNT_W-1:0] blink_cnt,
  input  logic             rpt,
  input  logic             stop,
  output logic             led,
  output logic             busy,
  output logic             done,
  output led_state_e       dbg_state
);

  localparam int TW = timer_w(ON_CYC, OFF_CYC, GAP_CYC);
  localparam logic [TW-1:0]    ON_LD   = TW'(ON_CYC - 1);
  localparam logic [TW-1:0]    OFF_LD  = TW'(OFF_CYC - 1);
  localparam logic [TW-1:0]    GAP_LD  = TW'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  led_state_e       state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] cur_cnt_q, cur_cnt_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             led_q, led_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;
  logic             trig_ok;
  logic             seq_end;

  seq_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign trig_ok = trig && (blink_cnt != '0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      cur_cnt_q  <= '0;
      pend_cnt_q <= '0;
      pend_vld_q <= 1'b0;
      led_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      cur_cnt_q  <= cur_cnt_d;
      pend_cnt_q <= pend_cnt_d;
      pend_vld_q <= pend_vld_d;
      led_q      <= led_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    cur_cnt_d  = cur_cnt_q;
    pend_cnt_d = pend_cnt_q;
    pend_vld_d = pend_vld_q;
    tmr_load   = 1'b0;
    tmr_val    = ON_LD;
    seq_end    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_ok) begin
          cur_cnt_d  = blink_cnt;
          remain_d   = blink_cnt;
          pend_vld_d = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = ON_LD;
          state_d    = ST_ON;
        end else if (pend_vld_q) begin
          // Restart with the count parked during the previous sequence.
          cur_cnt_d  = pend_cnt_q;
          remain_d   = pend_cnt_q;
          pend_vld_d = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = ON_LD;
          state_d    = ST_ON;
        end
      end
      ST_ON: begin
        if (tmr_zero) begin
          remain_d = remain_q - CNT_ONE;
          tmr_load = 1'b1;
          tmr_val  = OFF_LD;
          state_d  = ST_OFF;
        end
      end
      ST_OFF: begin
        if (tmr_zero) begin
          if (remain_q != '0) begin
            tmr_load = 1'b1;
            tmr_val  = ON_LD;
            state_d  = ST_ON;
          end else if (rpt) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
            state_d  = ST_GAP;
          end else begin
            seq_end = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          if (pend_vld_q) begin
            cur_cnt_d  = pend_cnt_q;
            remain_d   = pend_cnt_q;
            pend_vld_d = 1'b0;
          end else begin
            remain_d = cur_cnt_q;
          end
          tmr_load = 1'b1;
          tmr_val  = ON_LD;
          state_d  = ST_ON;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A trigger during a running sequence only parks its count; placed
    // after the GAP consume so a same-cycle trigger is not lost.
    if (trig_ok && (state_q != ST_IDLE)) begin
      pend_cnt_d = blink_cnt;
      pend_vld_d = 1'b1;
    end

    // Abort overrides everything, including a simultaneous trigger.
    if (stop) begin
      state_d    = ST_IDLE;
      pend_vld_d = 1'b0;
      seq_end    = 1'b0;
      tmr_load   = 1'b0;
      remain_d   = remain_q;
      cur_cnt_d  = cur_cnt_q;
    end
  end

  // Output decode; led and done are registered from next-state values.
  always_comb begin
    led_d  = (state_d == ST_ON);
    done_d = seq_end;
  end

  assign led       = led_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_blink_seq.sv
// Self-checking bench for led_blink_seq with ON=3, OFF=2, GAP=4.
// Cycle numbering: a trigger sampled at edge k affects cycle k+1, the
// interval following that edge. Each call to cyc() drives inputs for
// one edge, then pops and checks {led,busy,done} for the next cycle.
module tb_led_blink_seq;
  import led_seq_pkg::*;

  localparam int ON_CYC  = 3;
  localparam int OFF_CYC = 2;
  localparam int GAP_CYC = 4;
  localparam int CNT_W   = 4;

  localparam logic [2:0] E_ON   = 3'b110;
  localparam logic [2:0] E_OFF  = 3'b010;
  localparam logic [2:0] E_DONE = 3'b001;
  localparam logic [2:0] E_IDLE = 3'b000;

  logic             clk;
  logic             rst_n;
  logic             trig;
  logic [CNT_W-1:0] blink_cnt;
  logic             rpt;
  logic             stop;
  logic             led;
  logic             busy;
  logic             done;
  led_state_e       dbg_state;

  logic [2:0] exp_q[$];
  int         n_vec;
  int         n_err;
  string      scen;

  led_blink_seq #(
    .ON_CYC  (ON_CYC),
    .OFF_CYC (OFF_CYC),
    .GAP_CYC (GAP_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .blink_cnt (blink_cnt),
    .rpt       (rpt),
    .stop      (stop),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: {led,busy,done} got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input int cyc_no);
    string tag;
    tag = $sformatf("%s c%0d", scen, cyc_no);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no expected value queued, got %b", tag, {led, busy, done});
    end else begin
      check_eq(tag, {led, busy, done}, exp_q.pop_front());
    end
  endtask

  // Scoreboard producers
  task automatic push_n(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // N blinks followed by the done cycle of a non-repeating end.
  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      push_n(E_ON, ON_CYC);
      push_n(E_OFF, OFF_CYC);
    end
    push_n(E_DONE, 1);
  endtask

  // Driver: inputs for one edge, then check the following cycle.
  int cyc_no;
  task automatic cyc(input logic t, input logic [CNT_W-1:0] n, input logic r, input logic s);
    trig      = t;
    blink_cnt = n;
    rpt       = r;
    stop      = s;
    @(posedge clk);
    #1;
    trig = 1'b0;
    stop = 1'b0;
    cyc_no++;
    @(negedge clk);
    check_out(cyc_no);
  endtask

  task automatic start_scen(input string name);
    scen   = name;
    cyc_no = 0;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: %0d expected values left over", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    n_vec     = 0;
    n_err     = 0;
    cyc_no    = 0;
    scen      = "reset";
    rst_n     = 1'b0;
    trig      = 1'b0;
    blink_cnt = '0;
    rpt       = 1'b0;
    stop      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset", {led, busy, done}, E_IDLE);
    rst_n = 1'b1;

    // Basic 2-blink sequence.
    start_scen("basic");
    push_seq(2);
    push_n(E_IDLE, 1);
    cyc(1'b1, 4'd2, 1'b0, 1'b0);
    repeat (11) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Zero-count trigger is ignored.
    start_scen("zero");
    push_n(E_IDLE, 5);
    cyc(1'b1, 4'd0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Repeat mode, one blink, then abort.
    start_scen("repeat");
    push_n(E_ON, 3);
    push_n(E_OFF, 2);
    push_n(E_OFF, 4);
    push_n(E_ON, 3);
    push_n(E_OFF, 2);
    push_n(E_IDLE, 3);
    cyc(1'b1, 4'd1, 1'b1, 1'b0);
    repeat (13) cyc(1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Retrigger during a non-repeating sequence: done, then restart.
    start_scen("retrig");
    push_seq(1);
    push_seq(3);
    push_n(E_IDLE, 1);
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Later retrigger overwrites the earlier pending count.
    start_scen("overwrite");
    push_seq(2);
    push_seq(1);
    push_n(E_IDLE, 1);
    cyc(1'b1, 4'd2, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 4'd1, 1'b0, 1'b0);
    repeat (15) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Pending count applied at GAP->ON, repeat then dropped.
    start_scen("gap_pend");
    push_n(E_ON, 3);
    push_n(E_OFF, 2);
    push_n(E_OFF, 4);
    push_seq(2);
    push_n(E_IDLE, 1);
    cyc(1'b1, 4'd1, 1'b1, 1'b0);
    cyc(1'b1, 4'd2, 1'b1, 1'b0);
    repeat (10) cyc(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (9) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Stop mid-sequence: immediate idle, no done.
    start_scen("stop");
    push_n(E_ON, 2);
    push_n(E_IDLE, 6);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Simultaneous trig and stop in IDLE.
    start_scen("trig_stop");
    push_n(E_IDLE, 5);
    cyc(1'b1, 4'd5, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    // Random counts up to the maximum.
    for (int k = 0; k < 3; k++) begin
      start_scen($sformatf("rand%0d", k));
      n = (k == 0) ? 15 : $urandom_range(1, 15);
      push_seq(n);
      push_n(E_IDLE, 2);
      cyc(1'b1, CNT_W'(n), 1'b0, 1'b0);
      repeat (n * (ON_CYC + OFF_CYC) + 2) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-ON, no clock edge before the check.
    start_scen("async_rst");
    push_n(E_ON, 2);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst out", {led, busy, done}, E_IDLE);
    check_eq("async_rst state", {1'b0, dbg_state}, {1'b0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    push_n(E_IDLE, 3);
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 1'b0);

    start_scen("end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_blink_seq.md
# led_blink_seq

Sequenced LED output driver: converts single-cycle internal event pulses into human-visible blink patterns of N blinks on a board LED. It is the output-side counterpart of the push-button input conditioning. Button presses come in as raw levels and become one-cycle events; this block takes one-cycle events from flight-control logic (arm, calibration done, fault) and drives a held, timed level out to the board. It sits between the controller state logic and the LED pin.

## Interface
Parameters:
- ON_CYC, default 12_500_000: LED-on cycles per blink (250 ms at 50 MHz).
- OFF_CYC, default 12_500_000: LED-off cycles after each blink.
- GAP_CYC, default 50_000_000: extra off cycles between repeated sequences.
- CNT_W, default 4: width of the blink count.

Ports:
- clk, input, 1: system clock. Single clock domain.
- rst_n, input, 1: reset. Asynchronous, active-low.
- trig, input, 1: one-cycle start pulse. Synchronous to clk.
- blink_cnt, input, CNT_W: number of blinks. Sampled when trig=1.
- rpt, input, 1: repeat mode. Sampled at the end of each sequence.
- stop, input, 1: abort request.
- led, output, 1: LED drive, active-high, registered.
- busy, output, 1: a sequence is in progress.
- done, output, 1: one-cycle pulse when a non-repeating sequence completes normally.

## Operation
- States: IDLE, ON, OFF, GAP.
- Registers:
  - timer: width $clog2 of max(ON_CYC, OFF_CYC, GAP_CYC).
  - remain: CNT_W bits.
  - cur_cnt: CNT_W bits.
  - pend_cnt: CNT_W bits.
  - pend_vld: 1 bit.
- Reset values: state=IDLE; led=0, busy=0, done=0; all counters 0; pend_vld=0.
- IDLE:
  - trig=1 and blink_cnt≠0: cur_cnt and remain load blink_cnt, timer loads ON_CYC-1, go to ON.
  - trig with blink_cnt=0 is ignored.
- ON: led=1. At timer=0: decrement remain, load OFF_CYC-1, go to OFF.
- OFF: led=0. At timer=0:
  - remain≠0: go to ON.
  - remain=0 and rpt=1: load GAP_CYC-1, go to GAP.
  - remain=0 and rpt=0: go to IDLE and assert done for one cycle.
- GAP: led=0. At timer=0:
  - If pend_vld, cur_cnt takes pend_cnt and pend_vld clears.
  - remain takes cur_cnt, go to ON.
- Retrigger: trig with nonzero blink_cnt while not IDLE only stores pend_cnt and sets pend_vld. The running sequence is never altered.
  - A pending value is applied at the next GAP→ON transition.
  - If the sequence ends in IDLE instead, the pending value is applied as an immediate restart: IDLE is entered for exactly one cycle with done=1, then the block goes to ON with busy=1.
- A later trig overwrites pend_cnt (last write wins).
- stop=1 in any state, at the next edge:
  - state=IDLE, led=0, pend_vld=0, no done.
  - stop takes priority over a simultaneous trig.
- busy = (state≠IDLE). It is decoded from registered state, with no combinational path from inputs.
- done is registered.

## Timing
- trig sampled at edge k → led=1 and busy=1 from cycle k+1.
- Each blink is exactly ON_CYC high cycles followed by OFF_CYC low cycles.
- A full non-repeating N-blink sequence:
  - busy high for N·(ON_CYC+OFF_CYC) cycles.
  - done high in the first cycle after that, the same cycle busy falls.
- Repeat period = N·(ON_CYC+OFF_CYC)+GAP_CYC cycles. busy stays high through GAP.
- stop sampled at edge k → led=0, busy=0 at cycle k+1.
- rst_n assertion clears all outputs immediately (asynchronous), including mid-sequence.
- Maximum blink_cnt is 2^CNT_W−1; there is no wrap behaviour.

## Structure
- Package led_seq_pkg holds:
  - the state enum typedef (IDLE/ON/OFF/GAP);
  - a localparam function for the timer width.
- One sub-module, seq_timer: a loadable down-counter with load, load value and a zero flag. It is instantiated once and reused for the ON, OFF and GAP phases.

## Test plan
Params for all scenarios: ON_CYC=3, OFF_CYC=2, GAP_CYC=4.
- Basic, trig with blink_cnt=2 at edge 0:
  - led=1 cycles 1–3 and 6–8; led=0 cycles 4–5 and 9–10.
  - busy falls at 11 with done=1 at 11, for one cycle only.
- blink_cnt=0 trig → led, busy and done stay 0 throughout.
- rpt=1, blink_cnt=1 at edge 0:
  - led high 1–3 and 10–12.
  - busy continuous; done never asserted.
- Retrigger: blink_cnt=1 at edge 0, then trig with blink_cnt=3 at cycle 2:
  - First sequence unchanged.
  - done=1 at 6, then 3 blinks starting at cycle 7.
- stop at cycle 2 of a 3-blink sequence → led=0 and busy=0 at 3, no done.
- Simultaneous trig+stop in IDLE → no activity.
- Async rst_n pulse mid-ON → led=0 immediately, with no clock edge required.
